// File: rtl/sram_1p_init_ctrl.sv
// Request-side controller for a single-port, 1-cycle-latency SRAM macro.
// Sweeps every entry to INIT_VAL after reset, then arbitrates write/read requests (write wins).
module sram_1p_init_ctrl #(
    parameter int unsigned   DEPTH    = 1024,
    parameter int unsigned   AW       = 10,
    parameter int unsigned   DW       = 82,
    parameter logic [DW-1:0] INIT_VAL = '0
) (
    input  logic          clock,
    input  logic          reset,

    input  logic          w_req_valid,
    output logic          w_req_ready,
    input  logic [AW-1:0] w_req_addr,
    input  logic [DW-1:0] w_req_data,

    input  logic          r_req_valid,
    output logic          r_req_ready,
    input  logic [AW-1:0] r_req_addr,

    output logic          r_resp_valid,
    output logic [DW-1:0] r_resp_data,

    output logic          init_done,

    output logic          sram_en,
    output logic          sram_wmode,
    output logic [AW-1:0] sram_addr,
    output logic [DW-1:0] sram_wdata,
    input  logic [DW-1:0] sram_rdata
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int unsigned LAST_IDX = DEPTH - 1;
    localparam logic [AW:0] INIT_LAST = LAST_IDX[AW:0];

    state_t        state_q, state_d;
    logic [AW:0]   init_cnt_q, init_cnt_d;
    logic          init_done_q, init_done_d;
    logic          resp_valid_q, resp_valid_d;
    logic [DW-1:0] hold_q, hold_d;

    logic          run;
    logic          in_init;
    logic          wr_accept;
    logic          rd_accept;

    // Reset gates everything combinationally so a response in flight is dropped immediately.
    assign run       = (state_q == ST_RUN) && !reset;
    assign in_init   = (state_q == ST_INIT) && !reset;
    assign wr_accept = run && w_req_valid;
    assign rd_accept = run && r_req_valid && !w_req_valid;

    assign w_req_ready = run;
    assign r_req_ready = run && !w_req_valid;
    assign init_done   = init_done_q;

    always_comb begin
        sram_en    = 1'b0;
        sram_wmode = 1'b0;
        sram_addr  = r_req_addr;
        sram_wdata = w_req_data;
        if (in_init) begin
            sram_en    = 1'b1;
            sram_wmode = 1'b1;
            sram_addr  = init_cnt_q[AW-1:0];
            sram_wdata = INIT_VAL;
        end else if (wr_accept) begin
            sram_en    = 1'b1;
            sram_wmode = 1'b1;
            sram_addr  = w_req_addr;
        end else if (rd_accept) begin
            sram_en    = 1'b1;
            sram_addr  = r_req_addr;
        end
    end

    always_comb begin
        r_resp_valid = resp_valid_q && !reset;
        r_resp_data  = hold_q;
        if (reset) begin
            r_resp_data = '0;
        end else if (resp_valid_q) begin
            r_resp_data = sram_rdata;
        end
    end

    always_comb begin
        state_d      = state_q;
        init_cnt_d   = init_cnt_q;
        init_done_d  = init_done_q;
        resp_valid_d = rd_accept;
        hold_d       = resp_valid_q ? sram_rdata : hold_q;
        case (state_q)
            ST_INIT: begin
                init_cnt_d = init_cnt_q + 1'b1;
                if (init_cnt_q == INIT_LAST) begin
                    state_d     = ST_RUN;
                    init_done_d = 1'b1;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_INIT;
            init_cnt_q   <= '0;
            init_done_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            hold_q       <= '0;
        end else begin
            state_q      <= state_d;
            init_cnt_q   <= init_cnt_d;
            init_done_q  <= init_done_d;
            resp_valid_q <= resp_valid_d;
            hold_q       <= hold_d;
        end
    end

endmodule

// File: tb/tb_sram_1p_init_ctrl.sv
// Bench for sram_1p_init_ctrl: behavioural macro model, request-level reference memory,
// randomized traffic plus directed init / hold / collision / reset scenarios.
module tb_sram_1p_init_ctrl;

    localparam int DEPTH = 1024;
    localparam int AW    = 10;
    localparam int DW    = 82;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          w_req_valid = 1'b0;
    logic          w_req_ready;
    logic [AW-1:0] w_req_addr = '0;
    logic [DW-1:0] w_req_data = '0;
    logic          r_req_valid = 1'b0;
    logic          r_req_ready;
    logic [AW-1:0] r_req_addr = '0;
    logic          r_resp_valid;
    logic [DW-1:0] r_resp_data;
    logic          init_done;
    logic          sram_en;
    logic          sram_wmode;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata;
    logic [DW-1:0] sram_rdata;

    sram_1p_init_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .INIT_VAL('0)) dut (
        .clock        (clock),
        .reset        (reset),
        .w_req_valid  (w_req_valid),
        .w_req_ready  (w_req_ready),
        .w_req_addr   (w_req_addr),
        .w_req_data   (w_req_data),
        .r_req_valid  (r_req_valid),
        .r_req_ready  (r_req_ready),
        .r_req_addr   (r_req_addr),
        .r_resp_valid (r_resp_valid),
        .r_resp_data  (r_resp_data),
        .init_done    (init_done),
        .sram_en      (sram_en),
        .sram_wmode   (sram_wmode),
        .sram_addr    (sram_addr),
        .sram_wdata   (sram_wdata),
        .sram_rdata   (sram_rdata)
    );

    always #5 clock = ~clock;

    function automatic logic [DW-1:0] rnd82();
        logic [95:0] t;
        t = {$urandom, $urandom, $urandom};
        return t[DW-1:0] | {{(DW-1){1'b0}}, 1'b1};
    endfunction

    // Macro model, preloaded with garbage so the init sweep has something to clear.
    logic          preload = 1'b1;
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clock) begin
        if (preload) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= rnd82();
        end else if (sram_en) begin
            if (sram_wmode) mem[sram_addr] <= sram_wdata;
            else            sram_rdata     <= mem[sram_addr];
        end
    end

    // Request-level reference
    logic [DW-1:0] ref_mem [DEPTH];
    logic          exp_valid = 1'b0;
    logic [DW-1:0] exp_data  = '0;
    logic          exp_r_ready;
    logic          obs_w_ready, obs_r_ready, obs_en, obs_wm;
    logic [AW-1:0] obs_addr;
    int            checks = 0;
    int            passes = 0;

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic run_cycle(input logic wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                             input logic rv, input logic [AW-1:0] ra);
        w_req_valid = wv;
        w_req_addr  = wa;
        w_req_data  = wd;
        r_req_valid = rv;
        r_req_addr  = ra;
        #1;
        obs_w_ready = w_req_ready;
        obs_r_ready = r_req_ready;
        obs_en      = sram_en;
        obs_wm      = sram_wmode;
        obs_addr    = sram_addr;
        exp_r_ready = !wv;
        if (rv && !wv) begin
            exp_valid = 1'b1;
            exp_data  = ref_mem[ra];
        end else begin
            exp_valid = 1'b0;
        end
        if (wv) ref_mem[wa] = wd;
        cyc();
        w_req_valid = 1'b0;
        r_req_valid = 1'b0;
    endtask

    task automatic sweep(input int abort_at);
        reset = 1'b1;
        repeat (3) begin
            cyc();
            checks++; if (r_resp_valid !== 1'b0) $display("FAIL rst_resp_valid: got %b want 0", r_resp_valid); else passes++;
            checks++; if (r_resp_data !== '0) $display("FAIL rst_resp_data: got %h want 0", r_resp_data); else passes++;
            checks++; if (init_done !== 1'b0) $display("FAIL rst_init_done: got %b want 0", init_done); else passes++;
        end
        reset = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            w_req_valid = 1'($urandom_range(0, 1));
            r_req_valid = 1'($urandom_range(0, 1));
            #1;
            checks++; if ({sram_en, sram_wmode} !== 2'b11) $display("FAIL init_en_wmode @%0d: got %b want 11", i, {sram_en, sram_wmode}); else passes++;
            checks++; if (sram_addr !== AW'(i)) $display("FAIL init_addr: got %0d want %0d", sram_addr, i); else passes++;
            checks++; if (sram_wdata !== '0) $display("FAIL init_wdata @%0d: got %h want 0", i, sram_wdata); else passes++;
            checks++; if ({w_req_ready, r_req_ready} !== 2'b00) $display("FAIL init_ready @%0d: got %b want 00", i, {w_req_ready, r_req_ready}); else passes++;
            checks++; if (init_done !== 1'b0) $display("FAIL init_done_early @%0d: got %b want 0", i, init_done); else passes++;
            checks++; if ({r_resp_valid, r_resp_data} !== '0) $display("FAIL init_resp @%0d: got %h want 0", i, {r_resp_valid, r_resp_data}); else passes++;
            if (i == abort_at) return;
            cyc();
        end
        w_req_valid = 1'b0;
        r_req_valid = 1'b0;
        #1;
        checks++; if (init_done !== 1'b1) $display("FAIL init_done: got %b want 1", init_done); else passes++;
        checks++; if (w_req_ready !== 1'b1) $display("FAIL run_w_ready: got %b want 1", w_req_ready); else passes++;
        checks++; if (sram_en !== 1'b0) $display("FAIL idle_en: got %b want 0", sram_en); else passes++;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        exp_valid = 1'b0;
        exp_data  = '0;
        cyc();
    endtask

    task automatic test_reset();
        sweep(-1);
    endtask

    task automatic test_init_readback();
        logic [AW-1:0] addrs [3];
        addrs[0] = 10'd0; addrs[1] = 10'd511; addrs[2] = 10'd1023;
        for (int k = 0; k < 3; k++) begin
            run_cycle(1'b0, '0, '0, 1'b1, addrs[k]);
            checks++; if (obs_r_ready !== 1'b1) $display("FAIL b2b_r_ready %0d: got %b want 1", k, obs_r_ready); else passes++;
            checks++; if (r_resp_valid !== 1'b1) $display("FAIL b2b_valid %0d: got %b want 1", k, r_resp_valid); else passes++;
            checks++; if (r_resp_data !== exp_data) $display("FAIL b2b_data %0d: got %h want %h", k, r_resp_data, exp_data); else passes++;
        end
        run_cycle(1'b0, '0, '0, 1'b0, '0);
        checks++; if (r_resp_valid !== 1'b0) $display("FAIL b2b_end_valid: got %b want 0", r_resp_valid); else passes++;
    endtask

    task automatic test_write_read_hold();
        logic [DW-1:0] val;
        val = 82'h2AAAA_AAAA_AAAA_AAAA_AAAA;
        run_cycle(1'b1, 10'd5, val, 1'b0, '0);
        checks++; if (obs_w_ready !== 1'b1) $display("FAIL wr_ready: got %b want 1", obs_w_ready); else passes++;
        run_cycle(1'b0, '0, '0, 1'b1, 10'd5);
        checks++; if ({r_resp_valid, r_resp_data} !== {1'b1, val}) $display("FAIL wr_rd_data: got %b/%h want 1/%h", r_resp_valid, r_resp_data, val); else passes++;
        for (int k = 0; k < 10; k++) begin
            run_cycle(1'b0, '0, '0, 1'b0, '0);
            checks++; if ({r_resp_valid, r_resp_data} !== {1'b0, val}) $display("FAIL hold_idle %0d: got %b/%h want 0/%h", k, r_resp_valid, r_resp_data, val); else passes++;
        end
        run_cycle(1'b1, 10'd6, rnd82(), 1'b0, '0);
        checks++; if (r_resp_data !== val) $display("FAIL hold_write: got %h want %h", r_resp_data, val); else passes++;
        run_cycle(1'b0, '0, '0, 1'b1, 10'd6);
        checks++; if (r_resp_data !== exp_data) $display("FAIL rd6: got %h want %h", r_resp_data, exp_data); else passes++;
    endtask

    task automatic test_collision();
        run_cycle(1'b1, 10'd7, 82'h1, 1'b1, 10'd7);
        checks++; if ({obs_w_ready, obs_r_ready} !== 2'b10) $display("FAIL coll_ready: got %b want 10", {obs_w_ready, obs_r_ready}); else passes++;
        checks++; if ({obs_en, obs_wm, obs_addr} !== {2'b11, 10'd7}) $display("FAIL coll_port: got %b/%b/%0d want 1/1/7", obs_en, obs_wm, obs_addr); else passes++;
        checks++; if (r_resp_valid !== 1'b0) $display("FAIL coll_no_resp: got %b want 0", r_resp_valid); else passes++;
        run_cycle(1'b0, '0, '0, 1'b1, 10'd7);
        checks++; if (obs_r_ready !== 1'b1) $display("FAIL coll_retry_ready: got %b want 1", obs_r_ready); else passes++;
        checks++; if ({r_resp_valid, r_resp_data} !== {1'b1, 82'h1}) $display("FAIL coll_data: got %b/%h want 1/1", r_resp_valid, r_resp_data); else passes++;
    endtask

    task automatic test_random();
        logic          wv, rv, stalled;
        logic [AW-1:0] wa, ra;
        logic [DW-1:0] wd;
        stalled = 1'b0;
        rv = 1'b0;
        ra = '0;
        run_cycle(1'b1, 10'd300, rnd82(), 1'b0, '0);
        for (int k = 0; k < 400; k++) begin
            wv = ($urandom_range(0, 2) == 0);
            wa = AW'($urandom_range(0, 15));
            wd = rnd82();
            if (!stalled) begin
                rv = 1'($urandom_range(0, 1));
                ra = AW'($urandom_range(0, 15));
            end
            run_cycle(wv, wa, wd, rv, ra);
            checks++; if ({obs_w_ready, obs_r_ready} !== {1'b1, exp_r_ready}) $display("FAIL rnd_ready %0d: got %b want %b", k, {obs_w_ready, obs_r_ready}, {1'b1, exp_r_ready}); else passes++;
            checks++; if ({obs_en, obs_wm} !== {wv | rv, wv}) $display("FAIL rnd_port %0d: got %b want %b", k, {obs_en, obs_wm}, {wv | rv, wv}); else passes++;
            if (wv | rv) begin
                checks++; if (obs_addr !== (wv ? wa : ra)) $display("FAIL rnd_addr %0d: got %0d want %0d", k, obs_addr, wv ? wa : ra); else passes++;
            end
            checks++; if (r_resp_valid !== exp_valid) $display("FAIL rnd_valid %0d: got %b want %b", k, r_resp_valid, exp_valid); else passes++;
            checks++; if (r_resp_data !== exp_data) $display("FAIL rnd_data %0d: got %h want %h", k, r_resp_data, exp_data); else passes++;
            stalled = rv && wv;
        end
    endtask

    task automatic test_reset_mid_init();
        sweep(300);
        sweep(-1);
        run_cycle(1'b0, '0, '0, 1'b1, 10'd300);
        checks++; if ({r_resp_valid, r_resp_data} !== {1'b1, 82'h0}) $display("FAIL reinit_300: got %b/%h want 1/0", r_resp_valid, r_resp_data); else passes++;
    endtask

    task automatic test_reset_inflight();
        run_cycle(1'b1, 10'd9, rnd82(), 1'b0, '0);
        r_req_valid = 1'b1;
        r_req_addr  = 10'd9;
        #1;
        checks++; if (r_req_ready !== 1'b1) $display("FAIL infl_ready: got %b want 1", r_req_ready); else passes++;
        cyc();
        r_req_valid = 1'b0;
        reset = 1'b1;
        #1;
        checks++; if ({r_resp_valid, r_resp_data} !== '0) $display("FAIL infl_drop_n1: got %b/%h want 0/0", r_resp_valid, r_resp_data); else passes++;
        cyc();
        checks++; if ({r_resp_valid, r_resp_data} !== '0) $display("FAIL infl_drop_n2: got %b/%h want 0/0", r_resp_valid, r_resp_data); else passes++;
        sweep(-1);
        checks++; if ({r_resp_valid, r_resp_data} !== '0) $display("FAIL infl_after: got %b/%h want 0/0", r_resp_valid, r_resp_data); else passes++;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        @(posedge clock);
        #1;
        preload = 1'b0;
        test_reset();
        test_init_readback();
        test_write_read_hold();
        test_collision();
        test_random();
        test_reset_mid_init();
        test_reset_inflight();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
